// File: rtl/ins_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ins_fetch_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/ins_fetch_if.sv
// Instruction-memory req/gnt/rvalid bus; master is the fetch stage, slave the memory.
interface ins_fetch_if;
  import ins_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/ins_fetch_fifo.sv
// Show-ahead prefetch FIFO of {pc, instr} entries; clear has priority over push/pop.
module fetch_fifo
  import ins_fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  fetch_entry_t  wdata,
  input  logic          pop,
  output fetch_entry_t  rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: PC generation, credit-limited imem requests, prefetch FIFO, redirect flush.
// Optional FETCH_PERF_EN adds perf_fetch_cnt / perf_empty_cnt counters.
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  ins_fetch_if.master       imem,
  input  logic              redirect_in,
  input  logic [XLEN-1:0]   redirect_pc_in,
  input  logic              pipeline_stall_in,
  output logic              if_valid_out,
  output logic [XLEN-1:0]   if_instruction_out,
  output logic [XLEN-1:0]   if_pc_out,
  output logic [XLEN-1:0]   if_pc_plus_4_out
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_empty_cnt
`endif
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            started;
  logic            issue;
  logic            rsp;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  logic            unused_pc_bits;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  assign redirect_pc    = {redirect_pc_in[XLEN-1:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc_in[1:0];

  // Outstanding requests plus buffered words may never exceed the FIFO depth,
  // so every response is guaranteed a slot without backpressure on rvalid.
  assign credit_used   = {1'b0, inflight} + {1'b0, fifo_count};
  assign imem.imem_req = started && !redirect_in && !fifo_full
                         && (credit_used < (CW + 1)'(FIFO_DEPTH));
  assign imem.imem_addr = fetch_pc;

  assign issue = imem.imem_req && imem.imem_gnt;
  assign rsp   = imem.imem_rvalid && (inflight != '0);
  assign push  = rsp && (drop_cnt == '0) && !redirect_in;
  assign pop   = if_valid_out && !pipeline_stall_in && !redirect_in;

  assign push_entry = '{pc: resp_pc, instr: imem.imem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect_in),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign if_valid_out       = !fifo_empty;
  assign if_instruction_out = if_valid_out ? head.instr : NOP_INSTR;
  assign if_pc_out          = head.pc;
  assign if_pc_plus_4_out   = head.pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started  <= 1'b0;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      started  <= 1'b1;
      inflight <= inflight + CW'(issue) - CW'(rsp);
      if (redirect_in) begin
        // Everything still outstanding after this cycle belongs to the old path.
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= inflight - CW'(rsp);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push)  resp_pc  <= resp_pc + 32'd4;
        if (rsp && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_empty_cnt <= '0;
    end else begin
      if (pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!if_valid_out && !pipeline_stall_in) perf_empty_cnt <= perf_empty_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_ins_fetch.sv
// Self-checking bench for ins_fetch: directed table, hand sequences, and randomized traffic vs a queue model.
module tb_ins_fetch;
  import ins_fetch_pkg::*;

  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        redirect_in;
  logic [31:0] redirect_pc_in;
  logic        pipeline_stall_in;
  logic        if_valid_out;
  logic [31:0] if_instruction_out;
  logic [31:0] if_pc_out;
  logic [31:0] if_pc_plus_4_out;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_empty_cnt;
`endif

  ins_fetch_if bus ();

  ins_fetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .imem               (bus),
    .redirect_in        (redirect_in),
    .redirect_pc_in     (redirect_pc_in),
    .pipeline_stall_in  (pipeline_stall_in),
    .if_valid_out       (if_valid_out),
    .if_instruction_out (if_instruction_out),
    .if_pc_out          (if_pc_out),
    .if_pc_plus_4_out   (if_pc_plus_4_out)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt     (perf_fetch_cnt),
    .perf_empty_cnt     (perf_empty_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: requests carry the path epoch they were issued on; a response
  // from an older epoch is stale. The decode queue holds {pc, word} in order.
  typedef struct { logic [31:0] addr; int unsigned due; int unsigned epoch; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { bit gnt; bit stall; bit exp_req; logic [31:0] exp_addr; bit exp_valid; logic [31:0] exp_pc; } vec_t;

  pend_t       pend_q[$];
  ent_t        fifo_q[$];
  logic [31:0] m_fetch;
  int unsigned m_epoch;
  bit          m_started;
  int unsigned m_pf, m_pe;
  int unsigned cyc;
  int unsigned lat_min, lat_max;
  bit          s_rv;
  int          tests, fails;
  int          guard, pops;
  logic [31:0] a0, hold_pc, hold_ins;
  bit          rg, rs, rr;
  logic [31:0] rt;
  vec_t        vt[7];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input bit gnt, input bit stall, input bit redir, input logic [31:0] rpc);
    bus.imem_gnt      = gnt;
    pipeline_stall_in = stall;
    redirect_in       = redir;
    redirect_pc_in    = rpc;
    s_rv = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
    bus.imem_rvalid = s_rv;
    bus.imem_rdata  = s_rv ? mem_word(pend_q[0].addr) : $urandom;
    #1;
  endtask

  task automatic check_and_advance();
    bit exp_req, exp_valid, popped;
    pend_t r;
    exp_req   = m_started && !redirect_in && (pend_q.size() + fifo_q.size() < DEPTH);
    exp_valid = fifo_q.size() > 0;
    chk("imem_req", 32'(bus.imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", bus.imem_addr, m_fetch);
    chk("if_valid", 32'(if_valid_out), 32'(exp_valid));
    if (exp_valid) begin
      chk("if_pc", if_pc_out, fifo_q[0].pc);
      chk("if_instr", if_instruction_out, fifo_q[0].instr);
      chk("if_pc4", if_pc_plus_4_out, fifo_q[0].pc + 32'd4);
    end else begin
      chk("if_instr_nop", if_instruction_out, NOP_INSTR);
    end
`ifdef FETCH_PERF_EN
    chk("perf_fetch", perf_fetch_cnt, m_pf);
    chk("perf_empty", perf_empty_cnt, m_pe);
`endif
    popped = exp_valid && !pipeline_stall_in && !redirect_in;
    if (popped) begin
      void'(fifo_q.pop_front());
      m_pf++;
    end
    if (!exp_valid && !pipeline_stall_in) m_pe++;
    if (s_rv) begin
      r = pend_q.pop_front();
      if (!redirect_in && r.epoch == m_epoch) fifo_q.push_back('{r.addr, mem_word(r.addr)});
    end
    if (exp_req && bus.imem_gnt) begin
      pend_q.push_back('{m_fetch, cyc + $urandom_range(lat_max, lat_min), m_epoch});
      m_fetch += 32'd4;
    end
    if (redirect_in) begin
      fifo_q.delete();
      m_epoch++;
      m_fetch = {redirect_pc_in[31:2], 2'b00};
    end
    m_started = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(if_valid_out), 32'd0);
    chk({tag, "_instr"}, if_instruction_out, NOP_INSTR);
    chk({tag, "_pc"}, if_pc_out, 32'd0);
    chk({tag, "_pc4"}, if_pc_plus_4_out, 32'd4);
    chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
`ifdef FETCH_PERF_EN
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 32'd0);
    chk({tag, "_perf_empty"}, perf_empty_cnt, 32'd0);
`endif
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    redirect_in = 1'b0;
    redirect_pc_in = '0;
    pipeline_stall_in = 1'b0;
    #1;
    check_reset_outputs("rst");
    pend_q.delete();
    fifo_q.delete();
    m_fetch = RST_PC;
    m_started = 1'b0;
    m_pf = 0;
    m_pe = 0;
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; m_epoch = 0; pops = 0;
    lat_min = 1; lat_max = 1;
    // cycle 0 is the release cycle; rows are hand-derived for gnt=1, 1-cycle latency
    vt[0] = '{1, 0, 0, 32'h0, 0, 32'h0};
    vt[1] = '{1, 0, 1, 32'h0, 0, 32'h0};
    vt[2] = '{1, 0, 1, 32'h4, 0, 32'h0};
    vt[3] = '{1, 0, 0, 32'h0, 1, 32'h0};
    vt[4] = '{1, 0, 1, 32'h8, 1, 32'h4};
    vt[5] = '{1, 0, 1, 32'hC, 0, 32'h0};
    vt[6] = '{1, 0, 0, 32'h0, 1, 32'h8};

    @(posedge clk);
    #1;
    do_reset(2);

    for (int i = 0; i < 7; i++) begin
      drive(vt[i].gnt, vt[i].stall, 1'b0, 32'h0);
      chk("tbl_req", 32'(bus.imem_req), 32'(vt[i].exp_req));
      if (vt[i].exp_req) chk("tbl_addr", bus.imem_addr, vt[i].exp_addr);
      chk("tbl_valid", 32'(if_valid_out), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) chk("tbl_pc", if_pc_out, vt[i].exp_pc);
      check_and_advance();
    end

    // stall: head frozen, FIFO fills, requests stop
    drive(1, 1, 0, 0);
    hold_pc = if_pc_out;
    hold_ins = if_instruction_out;
    check_and_advance();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 0);
      chk("stall_hold_pc", if_pc_out, hold_pc);
      chk("stall_hold_instr", if_instruction_out, hold_ins);
      if (i == 3) chk("stall_req_drop", 32'(bus.imem_req), 32'd0);
      check_and_advance();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0);
      check_and_advance();
    end

    // gnt withheld: request and address held, one advance on grant
    guard = 0;
    drive(0, 0, 0, 0);
    while (!bus.imem_req && guard < 10) begin
      check_and_advance();
      drive(0, 0, 0, 0);
      guard++;
    end
    chk("gnt0_req_seen", 32'(bus.imem_req), 32'd1);
    a0 = bus.imem_addr;
    for (int i = 0; i < 3; i++) begin
      check_and_advance();
      drive(0, 0, 0, 0);
      chk("gnt0_req_hold", 32'(bus.imem_req), 32'd1);
      chk("gnt0_addr_hold", bus.imem_addr, a0);
    end
    check_and_advance();
    drive(1, 0, 0, 0);
    chk("gnt1_addr", bus.imem_addr, a0);
    check_and_advance();
    guard = 0;
    drive(0, 0, 0, 0);
    while (!bus.imem_req && guard < 10) begin
      check_and_advance();
      drive(0, 0, 0, 0);
      guard++;
    end
    chk("gnt_advance_once", bus.imem_addr, a0 + 32'd4);
    check_and_advance();

    // redirect with two requests in flight: both responses are stale
    lat_min = 4; lat_max = 4;
    guard = 0;
    drive(1, 0, 0, 0);
    while (pend_q.size() < 2 && guard < 20) begin
      check_and_advance();
      drive(1, 0, 0, 0);
      guard++;
    end
    drive(1, 0, 1, 32'h100);
    lat_min = 1; lat_max = 1;
    check_and_advance();
    guard = 0;
    drive(1, 0, 0, 0);
    while (!if_valid_out && guard < 40) begin
      check_and_advance();
      drive(1, 0, 0, 0);
      guard++;
    end
    chk("redir2_first_pc", if_pc_out, 32'h100);
    chk("redir2_first_instr", if_instruction_out, mem_word(32'h100));
    check_and_advance();

    // redirect coincident with rvalid and a pop; low PC bits must be ignored
    guard = 0;
    drive(1, 0, 0, 0);
    while (!(s_rv && if_valid_out) && guard < 30) begin
      check_and_advance();
      drive(1, 0, 0, 0);
      guard++;
    end
    chk("coincide_found", 32'(s_rv && if_valid_out), 32'd1);
    drive(1, 0, 1, 32'h203);
    check_and_advance();
    drive(1, 0, 0, 0);
    chk("coincide_flush_valid", 32'(if_valid_out), 32'd0);
    check_and_advance();
    guard = 0;
    drive(1, 0, 0, 0);
    while (!if_valid_out && guard < 40) begin
      check_and_advance();
      drive(1, 0, 0, 0);
      guard++;
    end
    chk("coincide_first_pc", if_pc_out, 32'h200);
    check_and_advance();

    // randomized traffic, including redirects near the 2^32 wrap
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 2500; i++) begin
      rg = ($urandom_range(9, 0) < 7);
      rs = ($urandom_range(9, 0) < 3);
      rr = ($urandom_range(99, 0) < 4);
      rt = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
      drive(rg, rs, rr, rt);
      if (!rs && !rr && if_valid_out) pops++;
      check_and_advance();
    end
    chk("random_progress", 32'(pops > 200), 32'd1);

    // reset in the middle of traffic
    do_reset(3);
    drive(1, 0, 0, 0);
    chk("post_rst_req_off", 32'(bus.imem_req), 32'd0);
    check_and_advance();
    drive(1, 0, 0, 0);
    chk("post_rst_req", 32'(bus.imem_req), 32'd1);
    chk("post_rst_addr", bus.imem_addr, RST_PC);
    check_and_advance();
    for (int i = 0; i < 300; i++) begin
      rg = ($urandom_range(9, 0) < 7);
      rs = ($urandom_range(9, 0) < 3);
      rr = ($urandom_range(99, 0) < 4);
      rt = $urandom;
      drive(rg, rs, rr, rt);
      check_and_advance();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
